// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, flag bit positions and FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_COMP = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_SHL  = 3'b111;

  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_O = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2
  } seq_state_e;

  // Only the arithmetic ops update the architectural flags in the default build.
  function automatic logic op_sets_flags(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command and response port of the ALU sequencer.
// valid/ready: a command transfers on a rising edge where cmd_valid && cmd_ready; the
// controller holds the command stable until then. rsp_valid has no ready and pulses once.
interface alu_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [AW-1:0]     cmd_src_a;
  logic [AW-1:0]     cmd_src_b;
  logic [AW-1:0]     cmd_dst;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [3:0]        rsp_flags;

  modport master (
    output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst,
    input  cmd_ready, rsp_valid, rsp_data, rsp_flags
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst,
    output cmd_ready, rsp_valid, rsp_data, rsp_flags
  );
endinterface

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: two operand read ports, one debug read port,
// a host write port and a writeback port that wins on an address collision.
module alu_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              host_we,
  input  logic [AW-1:0]     host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (host_we) regs_d[host_addr] = host_data;
    // Writeback applied last so it overrides a host write to the same register.
    if (wb_we)   regs_d[wb_addr]   = wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven front end for the registered 8-bit ALU: IDLE -> EXEC -> CAPT per op.
// Build option: ALU_SEQ_FLAG_ALL_EN makes flags_q load on every opcode, not just ADD/SUB.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_sequencer_if.slave    cmd_if,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        flags_q,
  output seq_state_e        dbg_state
);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [AW-1:0]     dst_q, dst_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic [3:0]        flags_d;
  logic              load_flags;
  logic              wb_we;
  logic [DATA_W-1:0] src_a_data;
  logic [DATA_W-1:0] src_b_data;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_addr   (cmd_if.cmd_src_a),
    .ra_data   (src_a_data),
    .rb_addr   (cmd_if.cmd_src_b),
    .rb_data   (src_b_data),
    .dbg_addr  (rd_addr),
    .dbg_data  (rd_data),
    .host_we   (wr_en),
    .host_addr (wr_addr),
    .host_data (wr_data),
    .wb_we     (wb_we),
    .wb_addr   (dst_q),
    .wb_data   (alu_out)
  );

`ifdef ALU_SEQ_FLAG_ALL_EN
  assign load_flags = 1'b1;
`else
  assign load_flags = op_sets_flags(alu_op_q);
`endif

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    dst_d       = dst_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    flags_d     = flags_q;
    wb_we       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_if.cmd_valid) begin
          alu_a_d  = src_a_data;
          alu_b_d  = src_b_data;
          alu_op_d = cmd_if.cmd_op;
          dst_d    = cmd_if.cmd_dst;
          state_d  = ST_EXEC;
        end
      end
      // The ALU registers its result at the end of this cycle.
      ST_EXEC: state_d = ST_CAPT;
      ST_CAPT: begin
        wb_we       = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_out;
        rsp_flags_d = alu_flags;
        if (load_flags) flags_d = alu_flags;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      dst_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      dst_q       <= dst_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      flags_q     <= flags_d;
    end
  end

  assign cmd_if.cmd_ready = (state_q == ST_IDLE);
  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_data  = rsp_data_q;
  assign cmd_if.rsp_flags = rsp_flags_q;
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_op           = alu_op_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU with one-clock latency, register-file/flag
// reference model, directed scenarios followed by randomized ops and a mid-op reset.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_out;
  logic [3:0] alu_flags;
  logic [3:0] flags_q;
  seq_state_e dbg_state;

  alu_sequencer_if #(.DATA_W(8), .AW(3)) cmd_if ();

  alu_sequencer #(.DATA_W(8), .NREGS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_if    (cmd_if),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_flags (alu_flags),
    .flags_q   (flags_q),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural ALU ----------------
  function automatic logic [11:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    int         ua, ub, sa, sb, wide, swide;
    logic [7:0] r;
    logic [3:0] f;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    f  = 4'b0000;
    r  = 8'h00;
    case (op)
      OP_ADD: begin
        wide  = ua + ub;
        swide = sa + sb;
        r = 8'(wide);
        f[FLAG_C] = (wide > 255);
        f[FLAG_O] = (swide > 127) || (swide < -128);
      end
      OP_SUB: begin
        wide  = ua - ub;
        swide = sa - sb;
        r = 8'(wide);
        f[FLAG_C] = (wide < 0);
        f[FLAG_O] = (swide > 127) || (swide < -128);
      end
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_NOT:  r = ~a;
      OP_COMP: r = (a == b) ? 8'h01 : 8'h00;
      OP_SHR:  r = 8'(ua / 2);
      default: r = 8'(ua * 2);
    endcase
    f[FLAG_N] = r[7];
    f[FLAG_Z] = (r == 8'h00);
    return {f, r};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) {alu_flags, alu_out} <= 12'h000;
    else        {alu_flags, alu_out} <= alu_fn(alu_op, alu_a, alu_b);
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] m_regs [8];
  logic [3:0] m_flags;
  logic [7:0] exp_q [$];
  logic [7:0] obs_data;
  logic [3:0] obs_flags;
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit flags_update(input logic [2:0] op);
`ifdef ALU_SEQ_FLAG_ALL_EN
    return 1'b1;
`else
    return (op == OP_ADD) || (op == OP_SUB);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    m_regs[a] = d;
    rd_addr = a;
    #1 check("preload_rd", rd_data, d);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [2:0] sa, input logic [2:0] sb,
                       input logic [2:0] dst, input bit hw_en, input logic [2:0] hw_addr,
                       input logic [7:0] hw_data);
    logic [11:0] res;
    @(negedge clk);
    check("ready_idle", cmd_if.cmd_ready, 1'b1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_src_a = sa;
    cmd_if.cmd_src_b = sb;
    cmd_if.cmd_dst   = dst;
    res = alu_fn(op, m_regs[sa], m_regs[sb]);
    @(posedge clk); #1;                       // E0
    check("ready_e0", cmd_if.cmd_ready, 1'b0);
    check("alu_a", alu_a, m_regs[sa]);
    check("alu_b", alu_b, m_regs[sb]);
    check("alu_op", alu_op, op);
    check("rsp_valid_e0", cmd_if.rsp_valid, 1'b0);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    @(posedge clk); #1;                       // E1
    check("ready_e1", cmd_if.cmd_ready, 1'b0);
    check("rsp_valid_e1", cmd_if.rsp_valid, 1'b0);
    @(negedge clk);                           // CAPT cycle
    wr_en = hw_en; wr_addr = hw_addr; wr_data = hw_data;
    rd_addr = dst;
    exp_q.push_back(res[7:0]);
    @(posedge clk); #1;                       // E2
    if (hw_en) m_regs[hw_addr] = hw_data;
    m_regs[dst] = res[7:0];
    if (flags_update(op)) m_flags = res[11:8];
    obs_data  = cmd_if.rsp_data;
    obs_flags = cmd_if.rsp_flags;
    check("rsp_valid_e2", cmd_if.rsp_valid, 1'b1);
    check("rsp_data", cmd_if.rsp_data, exp_q.pop_front());
    check("rsp_flags", cmd_if.rsp_flags, res[11:8]);
    check("flags_q", flags_q, m_flags);
    check("ready_e2", cmd_if.cmd_ready, 1'b1);
    check("wb_rd", rd_data, m_regs[dst]);
    @(negedge clk);
    wr_en = 1'b0;
    if (hw_en) begin
      rd_addr = hw_addr;
      #1 check("host_rd", rd_data, m_regs[hw_addr]);
    end
    @(posedge clk); #1;
    check("rsp_pulse", cmd_if.rsp_valid, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = '0;
    cmd_if.cmd_src_a = '0; cmd_if.cmd_src_b = '0; cmd_if.cmd_dst = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_flags = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", cmd_if.cmd_ready, 1'b1);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_alu_op", alu_op, 3'b000);
    check("rst_rsp_valid", cmd_if.rsp_valid, 1'b0);
    check("rst_rsp_data", cmd_if.rsp_data, 8'h00);
    check("rst_rsp_flags", cmd_if.rsp_flags, 4'b0000);
    check("rst_flags_q", flags_q, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1 check("rst_reg", rd_data, 8'h00);
    end

    // ADD with overflow into the sign bit
    preload(3'd1, 8'h40);
    preload(3'd2, 8'h41);
    do_op(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 8'h00);
    check("add_data", obs_data, 8'h81);
    check("add_flags", obs_flags, 4'b0110);
    check("add_flags_q", flags_q, 4'b0110);

    // back-to-back: cmd_valid held high through the whole op
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_OR;
    cmd_if.cmd_src_a = 3'd1; cmd_if.cmd_src_b = 3'd2; cmd_if.cmd_dst = 3'd6;
    @(posedge clk); #1 check("b2b_ready_e0", cmd_if.cmd_ready, 1'b0);
    @(posedge clk); #1 check("b2b_ready_e1", cmd_if.cmd_ready, 1'b0);
    check("b2b_rsp_e1", cmd_if.rsp_valid, 1'b0);
    @(posedge clk); #1 check("b2b_ready_e2", cmd_if.cmd_ready, 1'b1);
    check("b2b_rsp_e2", cmd_if.rsp_valid, 1'b1);
    check("b2b_data_e2", cmd_if.rsp_data, 8'h41);
    @(posedge clk); #1 check("b2b_ready_e3", cmd_if.cmd_ready, 1'b0);
    check("b2b_rsp_e3", cmd_if.rsp_valid, 1'b0);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 check("b2b_rsp2", cmd_if.rsp_valid, 1'b1);
    check("b2b_data2", cmd_if.rsp_data, 8'h41);
    m_regs[6] = 8'h41;
    if (flags_update(OP_OR)) m_flags = 4'b0000;
    check("b2b_flags_q", flags_q, m_flags);

    // SUB to zero, then OR leaves flags_q alone unless all-op flag loading is built in
    preload(3'd1, 8'h40);
    do_op(OP_SUB, 3'd1, 3'd1, 3'd1, 1'b0, 3'd0, 8'h00);
    check("sub_data", obs_data, 8'h00);
    check("sub_flags_q", flags_q, 4'b0001);
    do_op(OP_OR, 3'd1, 3'd2, 3'd7, 1'b0, 3'd0, 8'h00);
    check("or_data", obs_data, 8'h41);
`ifdef ALU_SEQ_FLAG_ALL_EN
    check("or_flags_q", flags_q, 4'b0000);
`else
    check("or_flags_q", flags_q, 4'b0001);
`endif

    // COMP / NOT / SHL / SHR
    preload(3'd1, 8'h40);
    do_op(OP_COMP, 3'd1, 3'd1, 3'd0, 1'b0, 3'd0, 8'h00);
    check("comp_data", obs_data, 8'h01);
    preload(3'd4, 8'h53);
    do_op(OP_NOT, 3'd4, 3'd2, 3'd5, 1'b0, 3'd0, 8'h00);
    check("not_data", obs_data, 8'hAC);
    do_op(OP_SHL, 3'd4, 3'd2, 3'd6, 1'b0, 3'd0, 8'h00);
    check("shl_data", obs_data, 8'hA6);
    do_op(OP_SHR, 3'd4, 3'd2, 3'd7, 1'b0, 3'd0, 8'h00);
    check("shr_data", obs_data, 8'h29);

    // host write colliding with writeback, then to a different register
    preload(3'd2, 8'h41);
    do_op(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b1, 3'd3, 8'h55);
    rd_addr = 3'd3;
    #1 check("coll_same_r3", rd_data, 8'h81);
    do_op(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b1, 3'd5, 8'h55);
    rd_addr = 3'd5;
    #1 check("coll_diff_r5", rd_data, 8'h55);
    rd_addr = 3'd3;
    #1 check("coll_diff_r3", rd_data, 8'h81);

    // randomized ops against the model
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1)
        preload(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      do_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
            3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end

    // reset asserted during EXEC discards the in-flight op
    preload(3'd2, 8'h77);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_ADD;
    cmd_if.cmd_src_a = 3'd2; cmd_if.cmd_src_b = 3'd2; cmd_if.cmd_dst = 3'd2;
    @(posedge clk); #1 check("mid_ready_e0", cmd_if.cmd_ready, 1'b0);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_alu_a", alu_a, 8'h00);
    check("mid_alu_b", alu_b, 8'h00);
    check("mid_alu_op", alu_op, 3'b000);
    check("mid_rsp_valid", cmd_if.rsp_valid, 1'b0);
    check("mid_rsp_data", cmd_if.rsp_data, 8'h00);
    check("mid_rsp_flags", cmd_if.rsp_flags, 4'b0000);
    check("mid_flags_q", flags_q, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_flags = 4'b0000;
    #1 check("mid_ready_rel", cmd_if.cmd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 check("mid_no_rsp", cmd_if.rsp_valid, 1'b0);
    end
    rd_addr = 3'd2;
    #1 check("mid_dst_zero", rd_data, 8'h00);

    // sequencer works normally after the reset
    preload(3'd1, 8'h10);
    do_op(OP_ADD, 3'd1, 3'd1, 3'd4, 1'b0, 3'd0, 8'h00);
    check("post_rst_data", obs_data, 8'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
